// File: rtl/ovi_vpu_responder.sv
// Behavioural VPU responder for the OVI issue/dispatch/completed channels.
// Optional random completion latency is enabled by defining OVI_RESP_RANDLAT_EN.
module ovi_vpu_responder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LATENCY   = 3,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         ISSUE_VALID,
  input  logic [31:0]                  ISSUE_INSTR,
  input  logic [4:0]                   ISSUE_SB_ID,
  input  logic [39:0]                  ISSUE_CSR,
  input  logic [63:0]                  ISSUE_DATA,
  output logic                         ISSUE_CREDIT,
  input  logic                         DISPATCH_VALID,
  input  logic                         DISPATCH_NEXT_SENIOR,
  input  logic                         DISPATCH_KILL,
  input  logic [4:0]                   DISPATCH_SB_ID,
  output logic                         COMPLETED_VALID,
  output logic [4:0]                   COMPLETED_SB_ID,
  output logic [4:0]                   COMPLETED_FFLAGS,
  output logic                         COMPLETED_VXSAT,
  output logic [63:0]                  COMPLETED_DEST_REG,
  output logic [13:0]                  COMPLETED_VSTART,
  output logic                         COMPLETED_ILLEGAL,
  output logic                         PROTO_ERR,
  output logic [$clog2(DEPTH):0]       OCCUPANCY
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [7:0]    LAT_C   = 8'(LATENCY - 1);

  typedef enum logic [1:0] {H_IDLE, H_WAIT, H_DONE} head_state_e;
  typedef enum logic {T_INIT, T_RUN} top_state_e;

  // Handshake: ISSUE_VALID and DISPATCH_VALID are single-cycle strobes with no
  // back-pressure; the issuer may only issue against credits it holds, and
  // every strobe is consumed in the cycle it is high.

  logic [4:0]       sb_q   [DEPTH];
  logic [63:0]      data_q [DEPTH];
  logic [DEPTH-1:0] ill_q;
  logic [DEPTH-1:0] disp_q, disp_d, kill_q, kill_d;
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d, dptr_q, dptr_d;
  logic [CW-1:0]    count_q, count_d, undisp_q, undisp_d;
  logic [CW-1:0]    pend_q, pend_d, init_q, init_d;
  logic [7:0]       lat_q, lat_d, lat_load;
  logic             proto_q, proto_d;
  head_state_e      hs_q, hs_d;
  top_state_e       top_q, top_d;

  logic full, push, push_err, head_valid, disp_any, disp_apply, disp_kill, disp_err;
  logic disp_hit_head, head_disp, head_kill, pop, comp_valid, credit, run_pulse;
  logic issue_ill;

`ifdef OVI_RESP_RANDLAT_EN
  logic [7:0] lfsr_q;
  always_ff @(posedge CLK) begin
    if (RESET) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
  assign lat_load = {5'b0, lfsr_q[2:0]};
  logic unused_ok;
  assign unused_ok = ^{ISSUE_CSR, ISSUE_INSTR[31:7], LAT_C};
`else
  assign lat_load = LAT_C;
  logic unused_ok;
  assign unused_ok = ^{ISSUE_CSR, ISSUE_INSTR[31:7], LFSR_SEED};
`endif

  assign issue_ill = !(ISSUE_INSTR[6:0] inside {7'h57, 7'h07, 7'h27});

  // Dispatch targets the oldest undispatched entry; a malformed strobe is
  // flagged but still applied as a kill.
  always_comb begin
    full          = (count_q == DEPTH_C);
    push          = ISSUE_VALID && !full;
    push_err      = ISSUE_VALID && full;
    head_valid    = (count_q != '0);
    disp_any      = (undisp_q != '0);
    disp_apply    = DISPATCH_VALID && disp_any;
    disp_kill     = DISPATCH_KILL || !DISPATCH_NEXT_SENIOR;
    disp_err      = DISPATCH_VALID && (!disp_any || (DISPATCH_KILL == DISPATCH_NEXT_SENIOR) ||
                    (DISPATCH_SB_ID != sb_q[dptr_q]));
    disp_hit_head = disp_apply && (dptr_q == head_q);
    head_disp     = disp_q[head_q] || disp_hit_head;
    head_kill     = kill_q[head_q] || (disp_hit_head && disp_kill);
  end

  // Head FSM sees this cycle's dispatch so a freshly committed head starts at once.
  always_comb begin
    hs_d       = hs_q;
    lat_d      = lat_q;
    pop        = 1'b0;
    comp_valid = 1'b0;
    case (hs_q)
      H_IDLE: begin
        if (head_valid && head_disp) begin
          if (head_kill) begin
            pop = 1'b1;
          end else begin
            hs_d  = H_WAIT;
            lat_d = lat_load;
          end
        end
      end
      H_WAIT: begin
        if (lat_q == 8'd0) hs_d = H_DONE;
        else               lat_d = lat_q - 8'd1;
      end
      H_DONE: begin
        comp_valid = 1'b1;
        pop        = 1'b1;
        hs_d       = H_IDLE;
      end
      default: hs_d = H_IDLE;
    endcase
  end

  always_comb begin
    top_d     = top_q;
    init_d    = init_q;
    credit    = 1'b0;
    run_pulse = 1'b0;
    case (top_q)
      T_INIT: begin
        credit = (init_q != '0);
        if (init_q != '0) init_d = init_q - CW'(1);
        if (init_q <= CW'(1)) top_d = T_RUN;
      end
      T_RUN: begin
        credit    = (pend_q != '0);
        run_pulse = credit;
      end
      default: top_d = T_INIT;
    endcase
    pend_d = pend_q + CW'(pop) - CW'(run_pulse);
  end

  always_comb begin
    disp_d = disp_q;
    kill_d = kill_q;
    if (disp_apply) begin
      disp_d[dptr_q] = 1'b1;
      kill_d[dptr_q] = disp_kill;
    end
    if (push) begin
      disp_d[tail_q] = 1'b0;
      kill_d[tail_q] = 1'b0;
    end
    if (pop) begin
      disp_d[head_q] = 1'b0;
      kill_d[head_q] = 1'b0;
    end
    head_d   = head_q + AW'(pop);
    tail_d   = tail_q + AW'(push);
    dptr_d   = dptr_q + AW'(disp_apply);
    count_d  = count_q + CW'(push) - CW'(pop);
    undisp_d = undisp_q + CW'(push) - CW'(disp_apply);
    proto_d  = proto_q || push_err || disp_err;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      head_q   <= '0;
      tail_q   <= '0;
      dptr_q   <= '0;
      count_q  <= '0;
      undisp_q <= '0;
      disp_q   <= '0;
      kill_q   <= '0;
      pend_q   <= '0;
      init_q   <= DEPTH_C;
      lat_q    <= '0;
      proto_q  <= 1'b0;
      hs_q     <= H_IDLE;
      top_q    <= T_INIT;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      dptr_q   <= dptr_d;
      count_q  <= count_d;
      undisp_q <= undisp_d;
      disp_q   <= disp_d;
      kill_q   <= kill_d;
      pend_q   <= pend_d;
      init_q   <= init_d;
      lat_q    <= lat_d;
      proto_q  <= proto_d;
      hs_q     <= hs_d;
      top_q    <= top_d;
    end
  end

  // Payload storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      sb_q[tail_q]   <= ISSUE_SB_ID;
      data_q[tail_q] <= ISSUE_DATA;
      ill_q[tail_q]  <= issue_ill;
    end
  end

  assign ISSUE_CREDIT       = credit && !RESET;
  assign COMPLETED_VALID    = comp_valid && !RESET;
  assign COMPLETED_SB_ID    = COMPLETED_VALID ? sb_q[head_q] : '0;
  assign COMPLETED_DEST_REG = COMPLETED_VALID ? data_q[head_q] : '0;
  assign COMPLETED_ILLEGAL  = COMPLETED_VALID && ill_q[head_q];
  assign COMPLETED_FFLAGS   = '0;
  assign COMPLETED_VXSAT    = 1'b0;
  assign COMPLETED_VSTART   = '0;
  assign PROTO_ERR          = proto_q;
  assign OCCUPANCY          = count_q;

endmodule

// File: tb/tb_ovi_vpu_responder.sv
// Scoreboard bench for ovi_vpu_responder: directed scenarios then random traffic
// checked against a transaction-level schedule model.
module tb_ovi_vpu_responder;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  // ---------------- clock / reset / DUT ----------------
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ISSUE_VALID = 1'b0;
  logic [31:0] ISSUE_INSTR = '0;
  logic [4:0]  ISSUE_SB_ID = '0;
  logic [39:0] ISSUE_CSR = '0;
  logic [63:0] ISSUE_DATA = '0;
  logic        ISSUE_CREDIT;
  logic        DISPATCH_VALID = 1'b0;
  logic        DISPATCH_NEXT_SENIOR = 1'b0;
  logic        DISPATCH_KILL = 1'b0;
  logic [4:0]  DISPATCH_SB_ID = '0;
  logic        COMPLETED_VALID;
  logic [4:0]  COMPLETED_SB_ID;
  logic [4:0]  COMPLETED_FFLAGS;
  logic        COMPLETED_VXSAT;
  logic [63:0] COMPLETED_DEST_REG;
  logic [13:0] COMPLETED_VSTART;
  logic        COMPLETED_ILLEGAL;
  logic        PROTO_ERR;
  logic [2:0]  OCCUPANCY;

  always #5 CLK = ~CLK;

  ovi_vpu_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .LFSR_SEED(8'hA5)) dut (
    .CLK(CLK), .RESET(RESET),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_INSTR(ISSUE_INSTR), .ISSUE_SB_ID(ISSUE_SB_ID),
    .ISSUE_CSR(ISSUE_CSR), .ISSUE_DATA(ISSUE_DATA), .ISSUE_CREDIT(ISSUE_CREDIT),
    .DISPATCH_VALID(DISPATCH_VALID), .DISPATCH_NEXT_SENIOR(DISPATCH_NEXT_SENIOR),
    .DISPATCH_KILL(DISPATCH_KILL), .DISPATCH_SB_ID(DISPATCH_SB_ID),
    .COMPLETED_VALID(COMPLETED_VALID), .COMPLETED_SB_ID(COMPLETED_SB_ID),
    .COMPLETED_FFLAGS(COMPLETED_FFLAGS), .COMPLETED_VXSAT(COMPLETED_VXSAT),
    .COMPLETED_DEST_REG(COMPLETED_DEST_REG), .COMPLETED_VSTART(COMPLETED_VSTART),
    .COMPLETED_ILLEGAL(COMPLETED_ILLEGAL), .PROTO_ERR(PROTO_ERR), .OCCUPANCY(OCCUPANCY)
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  // Expected completion word: {due cycle[101:70], sb_id[69:65], dest_reg[64:1], illegal[0]}
  logic [101:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each entry gets its pop cycle when dispatched: processing starts when it is
  // both dispatched and at the head (previous entry gone); a kill leaves that
  // cycle, a commit completes LAT+1 cycles later.
  typedef struct {
    logic [4:0]  sb;
    logic [63:0] data;
    logic        ill;
    logic        disp;
    int          popc;
  } mentry_t;

  mentry_t mq[$];
  int      hf = 0;
  int      pend = 0;
  int      rel = 0;
  logic    proto_m = 1'b0;

  function automatic int oldest_undisp();
    for (int i = 0; i < mq.size(); i++)
      if (!mq[i].disp) return i;
    return -1;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic iv, input logic [4:0] isb,
                      input logic [31:0] iin, input logic [63:0] idat,
                      input logic dv, input logic dns, input logic dk, input logic [4:0] dsb);
    int c, occ, k, start;
    logic ec, kill;
    mentry_t e;
    @(posedge CLK);
    #1;
    RESET = rst; ISSUE_VALID = iv; ISSUE_SB_ID = isb; ISSUE_INSTR = iin; ISSUE_DATA = idat;
    ISSUE_CSR = 40'($urandom);
    DISPATCH_VALID = dv; DISPATCH_NEXT_SENIOR = dns; DISPATCH_KILL = dk; DISPATCH_SB_ID = dsb;
    @(negedge CLK);
    #1;
    c = cyc;
    if (rst) begin
      chk("credit_in_reset", 64'(ISSUE_CREDIT), 64'd0);
      mq.delete(); exp_q.delete();
      pend = 0; proto_m = 1'b0; hf = c + 1; rel = c + 1;
      mon_en = 1'b1;
      return;
    end
    while (mq.size() > 0 && mq[0].popc < c) void'(mq.pop_front());
    occ = mq.size();
    chk("occupancy", 64'(OCCUPANCY), 64'(occ));
    chk("proto_err", 64'(PROTO_ERR), 64'(proto_m));
    if (c < rel + DEPTH) ec = 1'b1;
    else begin
      ec = (pend > 0);
      if (ec) pend--;
    end
    chk("issue_credit", 64'(ISSUE_CREDIT), 64'(ec));
    if (dv) begin
      k = oldest_undisp();
      if (k < 0) proto_m = 1'b1;
      else begin
        kill = dk || !dns;
        if (dk == dns) proto_m = 1'b1;
        if (dsb != mq[k].sb) proto_m = 1'b1;
        mq[k].disp = 1'b1;
        start = (c > hf) ? c : hf;
        mq[k].popc = kill ? start : start + LAT + 1;
        hf = mq[k].popc + 1;
        if (!kill) exp_q.push_back({32'(start + LAT + 1), mq[k].sb, mq[k].data, mq[k].ill});
      end
    end
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].popc == c) pend++;
    if (iv) begin
      if (occ == DEPTH) proto_m = 1'b1;
      else begin
        e.sb = isb; e.data = idat; e.disp = 1'b0; e.popc = 32'h7fffffff;
        e.ill = !(iin[6:0] inside {7'h57, 7'h07, 7'h27});
        mq.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic issue(input logic [4:0] sb, input logic [31:0] ins, input logic [63:0] d);
    step(0, 1, sb, ins, d, 0, 0, 0, 0);
  endtask
  task automatic dispatch(input logic ns, input logic k, input logic [4:0] sb);
    step(0, 0, 0, 0, 0, 1, ns, k, sb);
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && int'(exp_q[0][101:70]) < cyc) begin
        n_tests++; n_fail++;
        $display("FAIL completion_missing: sb %0d due cycle %0d, none by cycle %0d",
                 exp_q[0][69:65], exp_q[0][101:70], cyc);
        void'(exp_q.pop_front());
      end
      if (COMPLETED_VALID === 1'b1) begin
        if (exp_q.size() == 0) chk("completion_unexpected", 64'(COMPLETED_SB_ID), 64'h20);
        else begin
          logic [101:0] x;
          x = exp_q.pop_front();
          chk("comp_cycle", 64'(cyc), 64'(x[101:70]));
          chk("comp_sb_id", 64'(COMPLETED_SB_ID), 64'(x[69:65]));
          chk("comp_dest_reg", COMPLETED_DEST_REG, x[64:1]);
          chk("comp_illegal", 64'(COMPLETED_ILLEGAL), 64'(x[0]));
          chk("comp_zero_fields", 64'({COMPLETED_FFLAGS, COMPLETED_VXSAT, COMPLETED_VSTART}), 64'd0);
        end
      end else begin
        chk("idle_payload_zero", 64'({COMPLETED_SB_ID, COMPLETED_ILLEGAL, COMPLETED_FFLAGS,
            COMPLETED_VXSAT, COMPLETED_VSTART}) | COMPLETED_DEST_REG, 64'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] ops [5];
    ops[0] = 7'h57; ops[1] = 7'h07; ops[2] = 7'h27; ops[3] = 7'h33; ops[4] = 7'h13;

    // Init credits then single committed instruction.
    do_reset(3);
    idle(6);
    issue(5'd3, 32'h02008057, 64'h1234);
    idle(2);
    dispatch(1, 0, 5'd3);
    idle(8);

    // Kill one, commit the other.
    issue(5'd1, 32'h02008057, 64'h11);
    issue(5'd2, 32'h00000007, 64'h22);
    dispatch(0, 1, 5'd1);
    dispatch(1, 0, 5'd2);
    idle(8);

    // Overflow: fifth issue dropped, sticky error.
    for (int i = 0; i < 5; i++) issue(5'(8 + i), 32'h00000027, 64'(100 + i));
    idle(1);
    for (int i = 0; i < 4; i++) dispatch(1, 0, 5'(8 + i));
    idle(20);

    // Wrong dispatch id and illegal opcode.
    do_reset(1);
    idle(5);
    issue(5'd7, 32'h00000033, 64'hBEEF);
    dispatch(1, 0, 5'd6);
    idle(8);
    // Malformed dispatch strobes and dispatch with nothing outstanding.
    issue(5'd9, 32'h00000057, 64'h9);
    dispatch(1, 1, 5'd9);
    dispatch(0, 0, 5'd9);
    idle(4);

    // Reset while entries are in flight: nothing completes.
    do_reset(1);
    idle(5);
    for (int i = 0; i < 3; i++) issue(5'(20 + i), 32'h00000057, 64'(i));
    for (int i = 0; i < 3; i++) dispatch(1, 0, 5'(20 + i));
    idle(2);
    do_reset(2);
    idle(10);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic rst, iv, dv, dns, dk;
      logic [4:0] dsb;
      logic [31:0] ins;
      int k, r;
      rst = ($urandom_range(0, 499) == 0);
      iv  = ($urandom_range(0, 2) == 0);
      ins = {25'($urandom), ops[$urandom_range(0, 4)]};
      k   = oldest_undisp();
      dv  = (k >= 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) == 0);
      dsb = (k >= 0) ? mq[k].sb : 5'($urandom);
      if ($urandom_range(0, 19) == 0) dsb = dsb ^ 5'($urandom_range(1, 31));
      r   = $urandom_range(0, 39);
      dk  = (r < 10) || (r == 39);
      dns = (r >= 10 && r < 38) || (r == 39);
      step(rst, iv, 5'($urandom), ins, {$urandom, $urandom}, dv, dns, dk, dsb);
    end
    idle(30);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
